// File: rtl/seq_multiplier32_pkg.sv
// Purpose : shared constants and FSM state encoding for the 32x32 sequential multiplier.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: WIDTH/ITER_COUNT/CNT_W constants, state_t typedef with IDLE/RUN/DONE codes.
package seq_multiplier32_pkg;

  localparam int WIDTH      = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 6;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier32_if.sv
// Purpose : start/busy/done request bus between the control unit and the multiplier.
// Latency : n/a (wires only).
// Backpr. : none; the requester must watch busy/done, start during a run is ignored.
// Signals : start, A, B (requester -> multiplier); busy, done, P (multiplier -> requester).
interface seq_multiplier32_if;
  import seq_multiplier32_pkg::*;

  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   P;

  modport master (output start, output A, output B, input busy, input done, input P);
  modport slave  (input start, input A, input B, output busy, output done, output P);

endinterface

// File: rtl/seq_multiplier32_adder32.sv
// Purpose : 32-bit ripple-carry adder built from a chain of full-adder cells.
// Latency : combinational.
// Backpr. : none.
// Ports   : a, b (addends), cin (carry in) -> sum, cout (carry out of bit 31).
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[32];

endmodule

// File: rtl/seq_multiplier32.sv
// Purpose : sequential 32x32 -> 64 multiplier, one shift-add (or radix-2 Booth) step per clock.
// Latency : 33 cycles from the accepting edge to the done pulse; back-to-back start from DONE.
// Backpr. : start is only taken in IDLE/DONE; while busy it is ignored, not queued.
// Ports   : clk, rst_n (async active-low), bus (slave: start/A/B in, busy/done/P out).
// Config  : define MUL_SIGNED_EN for two's-complement operands (Booth step with q_m1 and
//           subtract path); undefined builds the unsigned shift-add step only.
module seq_multiplier32
  import seq_multiplier32_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  seq_multiplier32_if.slave   bus
);

  state_t               state;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     acc;
  logic [WIDTH-1:0]     q;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   p;

  logic [WIDTH-1:0]     add_b;
  logic                 add_cin;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic                 acc_top;   // bit 32 of the step result, shifted into acc[31]
  logic [WIDTH-1:0]     acc_nxt;
  logic [WIDTH-1:0]     q_nxt;
  logic                 last_step;

  adder32 u_adder (
    .a    (acc),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (sum),
    .cout (cout)
  );

`ifdef MUL_SIGNED_EN
  logic q_m1;

  always_comb begin
    add_b   = '0;
    add_cin = 1'b0;
    case ({q[0], q_m1})
      2'b01:   add_b = m;
      2'b10: begin
        add_b   = ~m;
        add_cin = 1'b1;
      end
      default: add_b = '0;
    endcase
  end

  // True sign of the 33-bit sign-extended sum; keeps M = -2^31 subtracts exact.
  assign acc_top = acc[WIDTH-1] ^ add_b[WIDTH-1] ^ cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_m1 <= 1'b0;
    end else if (state == S_RUN) begin
      q_m1 <= q[0];
    end else if (bus.start) begin
      q_m1 <= 1'b0;
    end
  end
`else
  assign add_b   = q[0] ? m : '0;
  assign add_cin = 1'b0;
  assign acc_top = cout;
`endif

  assign acc_nxt   = {acc_top, sum[WIDTH-1:1]};
  assign q_nxt     = {sum[0], q[WIDTH-1:1]};
  assign last_step = (cnt == CNT_W'(ITER_COUNT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      m     <= '0;
      acc   <= '0;
      q     <= '0;
      cnt   <= '0;
      p     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            m     <= bus.A;
            acc   <= '0;
            q     <= bus.B;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            p     <= {acc_nxt, q_nxt};
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);
  assign bus.P    = p;

endmodule

// File: tb/tb_seq_multiplier32.sv
// Purpose : randomized scoreboard bench for seq_multiplier32 against an arithmetic reference.
// Latency : expects done on the 33rd cycle after each accepting edge.
// Backpr. : drives start only when the design is IDLE/DONE, except deliberate mid-run pulses.
module tb_seq_multiplier32;

  logic clk;
  logic rst_n;

  seq_multiplier32_if bus ();

  seq_multiplier32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] p;
    time         t;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] last_p;
  int          n_cmp;
  int          n_bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    return sa * sb;
`else
    return {32'd0, a} * {32'd0, b};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    e.p = ref_mul(a, b);
    e.t = $time + 325;
    exp_q.push_back(e);
    #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // One multiplication. ign_k > 0 pulses start at that run cycle with other operands;
  // rst_k > 0 asserts reset at that run cycle. Returns at the negedge of the DONE cycle.
  task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                         input int ign_k, input int rst_k);
    issue(a, b);
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_p", bus.P, 64'd0);
        exp_q.delete();
        last_p = 64'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == 1 || k == 32) check("busy_run", {63'd0, bus.busy}, 64'd1);
      if (k == 16) check("p_hold", bus.P, last_p);
      bus.start = (k == ign_k);
      if (k == ign_k) begin
        bus.A = $urandom;
        bus.B = $urandom;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_at_done", {63'd0, bus.busy}, 64'd0);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  initial begin
    bit   prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (prev_done) begin
          n_cmp++;
          n_bad++;
          $display("FAIL done_width: done high 2 cycles, got 1 expected 0 at t=%0t", $time);
        end
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_done: got done=1 expected no pending product at t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("product", bus.P, e.p);
          check("latency", 64'($time), 64'(e.t));
          last_p = e.p;
        end
      end
      prev_done = (bus.done === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    last_p    = 64'd0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    #1;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_p", bus.P, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_one(32'd7, 32'd6, 0, 0);
    @(negedge clk);
    run_one(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    @(negedge clk);
    run_one(32'hFFFF_FFFD, 32'd5, 0, 0);
    @(negedge clk);
    run_one(32'h8000_0000, 32'h8000_0000, 0, 0);
    @(negedge clk);

    // Mid-run start ignored, then a back-to-back start issued in the DONE cycle.
    run_one($urandom, $urandom, 10, 0);
    run_one($urandom, $urandom, 0, 0);
    @(negedge clk);

    // Reset in the middle of a run, then quiet idle, then a clean run.
    run_one($urandom, $urandom, 0, 15);
    repeat (5) begin
      @(negedge clk);
      check("post_rst_busy", {63'd0, bus.busy}, 64'd0);
      check("post_rst_p", bus.P, 64'd0);
    end
    run_one(32'h1234_5678, 32'h9ABC_DEF0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_one($urandom, $urandom, (i % 4 == 1) ? int'($urandom_range(2, 31)) : 0, 0);
    end

    repeat (3) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
